// File: rtl/frame_control_regs_pkg.sv
// Shared definitions for the frame control register block: register map,
// STATUS bit positions, ID constant and sequencer state encoding.
package frame_control_regs_pkg;

    localparam int unsigned REG_CTRL      = 0;
    localparam int unsigned REG_STATUS    = 1;
    localparam int unsigned REG_CORE_EN   = 2;
    localparam int unsigned REG_PULSE_LEN = 3;
    localparam int unsigned REG_IRQ_MASK  = 4;
    localparam int unsigned REG_FRAME_CNT = 5;
    localparam int unsigned REG_CORE_DONE = 6;
    localparam int unsigned REG_ID        = 7;

    localparam int unsigned STATUS_IRQ  = 0;
    localparam int unsigned STATUS_BUSY = 1;
    localparam int unsigned STATUS_DROP = 2;

    localparam logic [7:0] ID_VALUE = 8'hA2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        WAIT  = 2'd2
    } frame_state_t;

endpackage

// File: rtl/frame_control_regs_core_done_tracker.sv
// Sticky per-core completion bits, qualified by the mask latched at frame start.
module core_done_tracker #(
    parameter int CORE_NUM = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic [CORE_NUM-1:0] core_done,
    input  logic [CORE_NUM-1:0] active_mask,
    output logic [CORE_NUM-1:0] done,
    output logic                all_done
);

    // Accumulate done pulses from enabled cores; clear wins at frame start.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            done <= '0;
        end else begin
            done <= done | (core_done & active_mask);
        end
    end

    // Frame is complete once every core in the latched mask has reported.
    always_comb begin
        all_done = ((done & active_mask) == active_mask);
    end

endmodule

// File: rtl/frame_control_regs.sv
// HPS-facing control/status registers, start-pulse sequencer and frame
// completion tracking for the shader core array.
//
// state | meaning
// IDLE  | no frame running, waiting for a start request
// PULSE | start held high, pulse counter running down
// WAIT  | start low, waiting for all latched cores to report done
module frame_control_regs
    import frame_control_regs_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int CORE_NUM      = 4,
    parameter int ADDR_W        = 3,
    parameter int PULSE_W       = 8,
    parameter int PULSE_DEFAULT = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic                read,
    input  logic                write,
    input  logic [WIDTH-1:0]    data_write,
    output logic [WIDTH-1:0]    data_read,
    input  logic [CORE_NUM-1:0] core_done,
    output logic                start,
    output logic                busy,
    output logic                irq,
    output logic [CORE_NUM-1:0] core_en
);

    frame_state_t        state_q, state_d;
    logic [PULSE_W-1:0]  pulse_len_q;
    logic [PULSE_W-1:0]  pulse_cnt_q;
    logic [CORE_NUM-1:0] active_mask_q;
    logic [WIDTH-1:0]    frame_cnt_q;
    logic                irq_mask_q;
    logic                irq_pending_q;
    logic                start_dropped_q;
    logic [CORE_NUM-1:0] done_bits;
    logic                all_done;
    logic                start_req;
    logic                start_accept;
    logic                start_drop;
    logic                frame_done;
    logic [WIDTH-1:0]    rd_mux;

    function automatic logic wr_hit(input logic [ADDR_W-1:0] a, input int unsigned reg_idx);
        return (a == ADDR_W'(reg_idx));
    endfunction

    assign start_req = write && wr_hit(address, REG_CTRL) && data_write[0];
    assign busy      = (state_q != IDLE);
    assign start     = (state_q == PULSE);
    assign irq       = irq_pending_q & irq_mask_q;

    // Only record done pulses while a frame is running so CORE_DONE is stable between frames.
    core_done_tracker #(
        .CORE_NUM (CORE_NUM)
    ) u_tracker (
        .clk         (clk),
        .reset       (reset),
        .clear       (start_accept),
        .core_done   (core_done & {CORE_NUM{busy}}),
        .active_mask (active_mask_q),
        .done        (done_bits),
        .all_done    (all_done)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus single-cycle accept/drop/complete events.
    always_comb begin
        state_d      = state_q;
        start_accept = 1'b0;
        start_drop   = 1'b0;
        frame_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_req) begin
                    if (core_en != '0) begin
                        start_accept = 1'b1;
                        state_d      = PULSE;
                    end else begin
                        start_drop = 1'b1;
                    end
                end
            end
            PULSE: begin
                start_drop = start_req;
                if (pulse_cnt_q == PULSE_W'(1)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                start_drop = start_req;
                if (all_done) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pulse length counter and mask latched at frame start; zero length runs as one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_cnt_q   <= '0;
            active_mask_q <= '0;
        end else if (start_accept) begin
            pulse_cnt_q   <= (pulse_len_q == '0) ? PULSE_W'(1) : pulse_len_q;
            active_mask_q <= core_en;
        end else if (state_q == PULSE) begin
            pulse_cnt_q <= pulse_cnt_q - PULSE_W'(1);
        end
    end

    // Register file writes; hardware sets win over same-cycle software clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_en         <= '1;
            pulse_len_q     <= PULSE_W'(PULSE_DEFAULT);
            irq_mask_q      <= 1'b0;
            frame_cnt_q     <= '0;
            irq_pending_q   <= 1'b0;
            start_dropped_q <= 1'b0;
        end else begin
            if (write && wr_hit(address, REG_CORE_EN))
                core_en <= data_write[CORE_NUM-1:0];
            if (write && wr_hit(address, REG_PULSE_LEN))
                pulse_len_q <= data_write[PULSE_W-1:0];
            if (write && wr_hit(address, REG_IRQ_MASK))
                irq_mask_q <= data_write[0];

            if (write && wr_hit(address, REG_FRAME_CNT))
                frame_cnt_q <= frame_done ? WIDTH'(1) : '0;
            else if (frame_done)
                frame_cnt_q <= frame_cnt_q + WIDTH'(1);

            if (frame_done)
                irq_pending_q <= 1'b1;
            else if (write && wr_hit(address, REG_STATUS) && data_write[STATUS_IRQ])
                irq_pending_q <= 1'b0;

            if (start_drop)
                start_dropped_q <= 1'b1;
            else if (write && wr_hit(address, REG_STATUS) && data_write[STATUS_DROP])
                start_dropped_q <= 1'b0;
        end
    end

    // Read data selection; unused bits and CTRL read as zero.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_W'(REG_STATUS): begin
                rd_mux[STATUS_IRQ]  = irq_pending_q;
                rd_mux[STATUS_BUSY] = busy;
                rd_mux[STATUS_DROP] = start_dropped_q;
            end
            ADDR_W'(REG_CORE_EN):   rd_mux[CORE_NUM-1:0] = core_en;
            ADDR_W'(REG_PULSE_LEN): rd_mux[PULSE_W-1:0]  = pulse_len_q;
            ADDR_W'(REG_IRQ_MASK):  rd_mux[0]            = irq_mask_q;
            ADDR_W'(REG_FRAME_CNT): rd_mux               = frame_cnt_q;
            ADDR_W'(REG_CORE_DONE): rd_mux[CORE_NUM-1:0] = done_bits;
            ADDR_W'(REG_ID):        rd_mux               = WIDTH'(ID_VALUE);
            default:                rd_mux               = '0;
        endcase
    end

    // Registered read port; holds the last value between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_read <= '0;
        end else if (read) begin
            data_read <= rd_mux;
        end
    end

endmodule

// File: tb/tb_frame_control_regs.sv
// Directed bench for frame_control_regs with hand-computed expectations.
module tb_frame_control_regs;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] address = '0;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic [7:0] data_write = '0;
    logic [7:0] data_read;
    logic [3:0] core_done = '0;
    logic       start;
    logic       busy;
    logic       irq;
    logic [3:0] core_en;

    int n_checks = 0;
    int n_fail   = 0;

    frame_control_regs dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .read       (read),
        .write      (write),
        .data_write (data_write),
        .data_read  (data_read),
        .core_done  (core_done),
        .start      (start),
        .busy       (busy),
        .irq        (irq),
        .core_en    (core_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All tasks are entered and left on a falling edge.
    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        address    = a;
        data_write = d;
        write      = 1'b1;
        @(negedge clk);
        write      = 1'b0;
        data_write = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        read    = 1'b0;
        d       = data_read;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        chk(tag, {24'h0, d}, {24'h0, exp});
    endtask

    task automatic count_start(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (start) n++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_done(input logic [3:0] m);
        core_done = m;
        @(negedge clk);
        core_done = '0;
    endtask

    initial begin
        int n;
        logic [7:0] exp_rst [8];
        exp_rst = '{8'h00, 8'h00, 8'h0F, 8'h14, 8'h00, 8'h00, 8'h00, 8'hA2};

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset values
        chk("rst_start", {31'h0, start}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_data_read", {24'h0, data_read}, 32'h0);
        for (int a = 0; a < 8; a++) begin
            rd_chk($sformatf("rst_reg%0d", a), 3'(a), exp_rst[a]);
        end
        repeat (3) @(negedge clk);
        chk("read_hold", {24'h0, data_read}, 32'hA2);

        // Three-cycle start pulse, all cores enabled
        wr(3'd3, 8'd3);
        chk("pre_start_low", {31'h0, start}, 32'h0);
        wr(3'd0, 8'h01);
        count_start(8, n);
        chk("pulse3_len", n, 3);
        chk("pulse3_busy", {31'h0, busy}, 32'h1);
        rd_chk("pulse3_status", 3'd1, 8'h02);
        pulse_done(4'hF);
        @(negedge clk);
        chk("frame1_busy", {31'h0, busy}, 32'h0);
        rd_chk("frame1_cnt", 3'd5, 8'h01);
        wr(3'd5, 8'h00);
        rd_chk("frame_cnt_clear", 3'd5, 8'h00);
        wr(3'd1, 8'h01);
        rd_chk("status_w1c_irq", 3'd1, 8'h00);

        // Masked completion with CORE_EN=0101
        wr(3'd2, 8'h05);
        wr(3'd0, 8'h01);
        pulse_done(4'b0001);
        pulse_done(4'b0010);
        count_start(6, n);
        rd_chk("core_done_partial", 3'd6, 8'h01);
        chk("masked_busy", {31'h0, busy}, 32'h1);
        pulse_done(4'b0100);
        chk("busy_before_fall", {31'h0, busy}, 32'h1);
        @(negedge clk);
        chk("busy_after_fall", {31'h0, busy}, 32'h0);
        rd_chk("core_done_final", 3'd6, 8'h05);
        rd_chk("masked_frame_cnt", 3'd5, 8'h01);
        rd_chk("masked_status", 3'd1, 8'h01);
        chk("irq_masked", {31'h0, irq}, 32'h0);
        wr(3'd4, 8'h01);
        chk("irq_unmasked", {31'h0, irq}, 32'h1);
        wr(3'd1, 8'h01);
        chk("irq_cleared", {31'h0, irq}, 32'h0);

        // Start request while busy is dropped
        wr(3'd0, 8'h01);
        n = start ? 1 : 0;
        begin
            int m;
            wr(3'd0, 8'h01);
            count_start(30, m);
            n = n + m;
        end
        chk("no_second_pulse", n, 3);
        rd_chk("drop_status", 3'd1, 8'h06);
        wr(3'd1, 8'h04);
        rd_chk("drop_cleared", 3'd1, 8'h02);
        pulse_done(4'b0101);
        @(negedge clk);
        rd_chk("frame2_status", 3'd1, 8'h01);
        wr(3'd1, 8'h01);

        // W1C of irq_pending in the completion cycle loses
        wr(3'd0, 8'h01);
        count_start(8, n);
        pulse_done(4'b0101);
        wr(3'd1, 8'h01);
        rd_chk("w1c_race_status", 3'd1, 8'h01);
        rd_chk("w1c_race_cnt", 3'd5, 8'h03);

        // FRAME_CNT clear in the completion cycle leaves one
        wr(3'd0, 8'h01);
        count_start(8, n);
        pulse_done(4'b0101);
        wr(3'd5, 8'h00);
        rd_chk("cnt_clear_race", 3'd5, 8'h01);

        // Start with no cores enabled is dropped
        wr(3'd1, 8'h05);
        wr(3'd2, 8'h00);
        wr(3'd0, 8'h01);
        count_start(10, n);
        chk("core_en0_no_start", n, 0);
        rd_chk("core_en0_status", 3'd1, 8'h04);

        // Zero pulse length runs one cycle, then reset mid-WAIT
        wr(3'd2, 8'h0F);
        wr(3'd1, 8'h04);
        wr(3'd3, 8'h00);
        wr(3'd0, 8'h01);
        count_start(6, n);
        chk("pulse0_len", n, 1);
        chk("wait_busy", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_start", {31'h0, start}, 32'h0);
        chk("rst_mid_busy", {31'h0, busy}, 32'h0);
        rd_chk("rst_mid_cnt", 3'd5, 8'h00);
        rd_chk("rst_mid_pulse_len", 3'd3, 8'h14);
        rd_chk("rst_mid_status", 3'd1, 8'h00);

        // Normal frame after reset with default 20-cycle pulse
        wr(3'd0, 8'h01);
        count_start(30, n);
        chk("pulse20_len", n, 20);
        pulse_done(4'hF);
        @(negedge clk);
        chk("post_rst_busy", {31'h0, busy}, 32'h0);
        rd_chk("post_rst_cnt", 3'd5, 8'h01);
        rd_chk("post_rst_status", 3'd1, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
